// File: rtl/fifo_ctrl_ram_4x8.sv
// fifo_ctrl_ram_4x8
//   Controller that turns an external 4x8 single-port synchronous RAM into a
//   4-entry, 8-bit FIFO. It performs one RAM access per cycle, and pop has
//   priority over push.
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   push_valid/data  : enqueue request; push_ready gates acceptance
//   pop_req          : dequeue request
//   pop_valid/data   : 1-cycle pulse, 2 edges after the accepting edge; data held
//   count/full/empty : occupancy
//   ovf_err/udf_err  : sticky push-while-full / pop-while-empty
//   ram_*            : registered RAM controls, ram_dados_out is the RAM read data
module fifo_ctrl_ram_4x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              udf_err,
  output logic              ram_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dados_in,
  input  logic [DATA_W-1:0] ram_dados_out
);
  localparam int STAGES = 1;
  localparam logic [ADDR_W:0]   DEPTH_C = DEPTH;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  // vld_pipe[0]: pop accepted at the last edge (RAM read is in flight this cycle)
  // vld_pipe[1]: RAM read data is on ram_dados_out this cycle
  logic [STAGES:0]   vld_pipe;
  logic              pop_acc, push_acc;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign pop_acc    = pop_req && !empty;
  // The RAM has a single port, so a pop in the same cycle blocks the push.
  assign push_ready = !full && !pop_acc;
  assign push_acc   = push_valid && push_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      vld_pipe         <= '0;
      pop_valid        <= 1'b0;
      pop_data         <= '0;
      ovf_err          <= 1'b0;
      udf_err          <= 1'b0;
      ram_enable       <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_addr         <= '0;
      ram_dados_in     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], pop_acc};
      pop_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) pop_data <= ram_dados_out;

      ovf_err <= ovf_err | (push_valid && full);
      udf_err <= udf_err | (pop_req && empty);

      if (pop_acc) begin
        ram_enable       <= 1'b1;
        ram_write_enable <= 1'b0;
        ram_addr         <= rd_ptr;
        rd_ptr           <= rd_ptr + PTR_ONE;
        count            <= count - CNT_ONE;
      end else if (push_acc) begin
        ram_enable       <= 1'b1;
        ram_write_enable <= 1'b1;
        ram_addr         <= wr_ptr;
        ram_dados_in     <= push_data;
        wr_ptr           <= wr_ptr + PTR_ONE;
        count            <= count + CNT_ONE;
      end else begin
        // Idle: the address and write data hold their previous values.
        ram_enable       <= 1'b0;
        ram_write_enable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_ctrl_ram_4x8.sv
module tb_fifo_ctrl_ram_4x8;
  logic       clk = 1'b0;
  logic       reset;
  logic       push_valid, pop_req;
  logic [7:0] push_data;
  logic       push_ready, pop_valid, full, empty, ovf_err, udf_err;
  logic [7:0] pop_data, ram_dados_in;
  logic [7:0] ram_dados_out;
  logic [2:0] count;
  logic       ram_enable, ram_write_enable;
  logic [1:0] ram_addr;

  always #5 clk = ~clk;

  fifo_ctrl_ram_4x8 dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .count(count), .full(full), .empty(empty),
    .ovf_err(ovf_err), .udf_err(udf_err),
    .ram_enable(ram_enable), .ram_write_enable(ram_write_enable),
    .ram_addr(ram_addr), .ram_dados_in(ram_dados_in), .ram_dados_out(ram_dados_out)
  );

  // Synchronous single-port RAM with registered read data; never reset.
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_write_enable) mem[ram_addr] <= ram_dados_in;
      else                  ram_dados_out <= mem[ram_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, RAM addressing as push/pop
  // counts modulo depth, read results scheduled two edges after acceptance.
  logic [7:0] m_q[$];
  int         m_wr_n, m_rd_n;
  logic       m_ovf, m_udf, m_en, m_we, m_pv;
  logic [1:0] m_addr;
  logic [7:0] m_din, m_pd;
  logic       h0, h1;
  logic [7:0] h0d, h1d;

  task automatic m_reset();
    m_q.delete();
    m_wr_n = 0; m_rd_n = 0;
    m_ovf = 0; m_udf = 0; m_en = 0; m_we = 0; m_pv = 0;
    m_addr = 0; m_din = 0; m_pd = 0;
    h0 = 0; h1 = 0; h0d = 0; h1d = 0;
  endtask

  task automatic cyc(input logic pv, input logic [7:0] pd, input logic pr, input logic rst);
    logic pop_a, push_a, m_full, m_empty;
    @(negedge clk);
    push_valid = pv; push_data = pd; pop_req = pr; reset = rst;
    #1;
    m_full  = (m_q.size() == 4);
    m_empty = (m_q.size() == 0);
    pop_a   = pr && !m_empty;
    push_a  = pv && !m_full && !pop_a;
    chk("push_ready", push_ready, !m_full && !pop_a);
    @(posedge clk);
    #1;
    if (rst) m_reset();
    else begin
      m_pv = h1;
      if (h1) m_pd = h1d;
      h1 = h0; h1d = h0d;
      h0 = pop_a; h0d = pop_a ? m_q[0] : 8'h00;
      m_ovf |= pv && m_full;
      m_udf |= pr && m_empty;
      if (pop_a) begin
        m_en = 1; m_we = 0; m_addr = 2'(m_rd_n % 4);
        void'(m_q.pop_front()); m_rd_n++;
      end else if (push_a) begin
        m_en = 1; m_we = 1; m_addr = 2'(m_wr_n % 4); m_din = pd;
        m_q.push_back(pd); m_wr_n++;
      end else begin
        m_en = 0; m_we = 0;
      end
    end
    chk("count", count, m_q.size());
    chk("full", full, m_q.size() == 4);
    chk("empty", empty, m_q.size() == 0);
    chk("pop_valid", pop_valid, m_pv);
    chk("pop_data", pop_data, m_pd);
    chk("ovf_err", ovf_err, m_ovf);
    chk("udf_err", udf_err, m_udf);
    chk("ram_enable", ram_enable, m_en);
    chk("ram_write_enable", ram_write_enable, m_we);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_dados_in", ram_dados_in, m_din);
  endtask

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       pr;
    logic [2:0] ec;
    logic       een, ewe;
    logic [1:0] ea;
    logic       epv;
    logic [7:0] epd;
  } vec_t;
  vec_t vec [12];

  initial begin
    vec[0]  = '{1'b1, 8'hA0, 1'b0, 3'd1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00};
    vec[1]  = '{1'b1, 8'hA1, 1'b0, 3'd2, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00};
    vec[2]  = '{1'b1, 8'hA2, 1'b0, 3'd3, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00};
    vec[3]  = '{1'b1, 8'hA3, 1'b0, 3'd4, 1'b1, 1'b1, 2'd3, 1'b0, 8'h00};
    vec[4]  = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
    vec[6]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0, 2'd2, 1'b1, 8'hA0};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 2'd3, 1'b1, 8'hA1};
    vec[9]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'b1, 8'hA2};
    vec[10] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'b1, 8'hA3};
    vec[11] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'b0, 8'hA3};

    push_valid = 0; push_data = 0; pop_req = 0; reset = 1;
    m_reset();
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ram_enable", ram_enable, 0);

    // Fill, overflow attempt, drain back-to-back.
    for (int i = 0; i < 12; i++) begin
      cyc(vec[i].pv, vec[i].pd, vec[i].pr, 0);
      chk("vec_count", count, vec[i].ec);
      chk("vec_ram_en", ram_enable, vec[i].een);
      chk("vec_ram_we", ram_write_enable, vec[i].ewe);
      chk("vec_ram_addr", ram_addr, vec[i].ea);
      chk("vec_pop_valid", pop_valid, vec[i].epv);
      chk("vec_pop_data", pop_data, vec[i].epd);
      if (i == 3) chk("vec_full_ready", push_ready, 0);
      if (i == 4) chk("vec_ovf", ovf_err, 1);
    end

    // count==2, push and pop together: pop wins, push lands next cycle.
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 1, 0);
    chk("simul_count_after_pop", count, 1);
    cyc(1, 8'h33, 0, 0);
    chk("simul_count_restored", count, 2);
    cyc(0, 8'h00, 0, 0);
    chk("simul_first_pop", pop_data, 8'h11);

    // Wrap: interleaved push/pop rolls the pointers past 3.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 8'(8'hC0 + i), 0, 0);
      cyc(0, 8'h00, 1, 0);
      chk("wrap_count_max", int'(count <= 3'd4), 1);
    end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("wrap_empty", empty, 1);

    // Underflow, then reset right after a pop accept cancels the capture.
    cyc(0, 8'h00, 1, 0);
    chk("udf_set", udf_err, 1);
    cyc(1, 8'h77, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 0, 0);
      chk("rst_pending_pv", pop_valid, 0);
    end
    chk("rst_pending_count", count, 0);
    chk("rst_pending_udf", udf_err, 0);
    chk("rst_pending_ovf", ovf_err, 0);
    chk("rst_pending_pd", pop_data, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 60) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
